collector_fifo_sink: RTL and testbench

- Parametrised next-generation packet collector for the mesh NoC local port.
- Sinks packets from a router's local output with a Req/Gnt handshake and checks each packet's destination against its own ModuleID.
- Buffers accepted packets in an internal FIFO drained at a programmable rate, modelling a slow PE, so the router sees real UpStrFull backpressure.
- Exposes receive statistics as ports instead of file logging.

---
 rtl/collector_fifo_sink.sv | 162 ++++++++++++++++
 tb/tb_collector_fifo_sink.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/collector_fifo_sink.sv
// Packet collector for a mesh NoC local port. Accepts packets from the router
// with a Req/Gnt handshake and buffers them in a small FIFO. The FIFO is drained
// at a programmable rate to model a slow processing element. Receive statistics
// are exposed as output ports.
module collector_fifo_sink #(
  parameter int dataWidth    = 32,
  parameter int PID_W        = 10,
  parameter int ID_W         = 6,
  parameter int ModuleID     = 0,
  parameter int DEPTH        = 4,
  parameter int DRAIN_PERIOD = 4,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [dataWidth-1:0] PacketIn,
  input  logic                 ReqUpStr,
  output logic                 GntUpStr,
  output logic                 UpStrFull,
  output logic                 DrainValid,
  output logic [dataWidth-1:0] DrainData,
  output logic [CNT_W-1:0]     RxCount,
  output logic [CNT_W-1:0]     MisrouteCount,
  output logic [ID_W-1:0]      LastSenderID,
  output logic [PID_W-1:0]     LastPacketID,
  output logic [31:0]          CycleCount
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DCW-1:0]         drain_cnt_q, drain_cnt_d;
  logic                   drain_valid_q, drain_valid_d;
  logic [dataWidth-1:0]   drain_data_q, drain_data_d;
  logic [CNT_W-1:0]       rx_q, rx_d;
  logic [CNT_W-1:0]       mis_q, mis_d;
  logic [ID_W-1:0]        last_sender_q, last_sender_d;
  logic [PID_W-1:0]       last_pid_q, last_pid_d;
  logic [31:0]            cycle_q, cycle_d;
  logic [dataWidth-1:0]   mem_q [DEPTH];

  logic [PID_W-1:0] pkt_pid;
  logic [ID_W-1:0]  pkt_dest;
  logic [ID_W-1:0]  pkt_sender;
  logic             empty, full, push, pop, drain_hit;

  assign pkt_pid    = PacketIn[dataWidth-1 -: PID_W];
  assign pkt_dest   = PacketIn[dataWidth-PID_W-1 -: ID_W];
  assign pkt_sender = PacketIn[dataWidth-PID_W-ID_W-1 -: ID_W];

  // Handshake and drain decisions; the push check uses the pre-pop count so a
  // full FIFO rejects even when a pop happens in the same cycle.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
    push  = (state_q == IDLE) && ReqUpStr && !full;
    if (DRAIN_PERIOD <= 1) drain_hit = 1'b1;
    else                   drain_hit = (drain_cnt_q == DCW'(DRAIN_PERIOD - 1));
    pop   = !empty && drain_hit;
  end

  // Next-state logic for the handshake FSM, FIFO bookkeeping and statistics.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    drain_cnt_d   = drain_cnt_q;
    drain_valid_d = 1'b0;
    drain_data_d  = drain_data_q;
    rx_d          = rx_q;
    mis_d         = mis_q;
    last_sender_d = last_sender_q;
    last_pid_d    = last_pid_q;
    cycle_d       = cycle_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (push) begin
          state_d       = GRANT;
          wr_ptr_d      = wr_ptr_q + AW'(1);
          last_sender_d = pkt_sender;
          last_pid_d    = pkt_pid;
          if (rx_q != '1) rx_d = rx_q + CNT_W'(1);
          if ((pkt_dest != ID_W'(ModuleID)) && (mis_q != '1)) mis_d = mis_q + CNT_W'(1);
        end
      end
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (pop) begin
      rd_ptr_d      = rd_ptr_q + AW'(1);
      drain_valid_d = 1'b1;
      drain_data_d  = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Pacing counter only runs while there is something to drain.
    if (empty || drain_hit) drain_cnt_d = '0;
    else                    drain_cnt_d = drain_cnt_q + DCW'(1);
  end

  // State and statistics registers; reset discards any buffered packets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      drain_cnt_q   <= '0;
      drain_valid_q <= 1'b0;
      drain_data_q  <= '0;
      rx_q          <= '0;
      mis_q         <= '0;
      last_sender_q <= '0;
      last_pid_q    <= '0;
      cycle_q       <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      drain_cnt_q   <= drain_cnt_d;
      drain_valid_q <= drain_valid_d;
      drain_data_q  <= drain_data_d;
      rx_q          <= rx_d;
      mis_q         <= mis_d;
      last_sender_q <= last_sender_d;
      last_pid_q    <= last_pid_d;
      cycle_q       <= cycle_d;
    end
  end

  // FIFO storage write port; contents need no reset since pointers gate use.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= PacketIn;
  end

  assign GntUpStr      = (state_q == GRANT);
  assign UpStrFull     = full;
  assign DrainValid    = drain_valid_q;
  assign DrainData     = drain_data_q;
  assign RxCount       = rx_q;
  assign MisrouteCount = mis_q;
  assign LastSenderID  = last_sender_q;
  assign LastPacketID  = last_pid_q;
  assign CycleCount    = cycle_q;

endmodule

// File: tb/tb_collector_fifo_sink.sv
// Directed bench for collector_fifo_sink using three instances: a slow drain
// (period 8), a fast drain (period 0) and a narrow-counter fast drain.
module tb_collector_fifo_sink;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q_a[$], q_b[$], q_c[$];

  logic          req_a = 0, req_b = 0, req_c = 0;
  logic [DW-1:0] pkt_a = '0, pkt_b = '0, pkt_c = '0;
  logic          gnt_a, gnt_b, gnt_c, full_a, full_b, full_c, dv_a, dv_b, dv_c;
  logic [DW-1:0] dd_a, dd_b, dd_c;
  logic [15:0]   rx_a, mis_a, rx_b, mis_b;
  logic [3:0]    rx_c, mis_c;
  logic [5:0]    ls_a, ls_b, ls_c;
  logic [9:0]    lp_a, lp_b, lp_c;
  logic [31:0]   cc_a, cc_b, cc_c;

  collector_fifo_sink #(.DEPTH(4), .DRAIN_PERIOD(8), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst_n), .PacketIn(pkt_a), .ReqUpStr(req_a), .GntUpStr(gnt_a),
    .UpStrFull(full_a), .DrainValid(dv_a), .DrainData(dd_a), .RxCount(rx_a),
    .MisrouteCount(mis_a), .LastSenderID(ls_a), .LastPacketID(lp_a), .CycleCount(cc_a));

  collector_fifo_sink #(.DEPTH(4), .DRAIN_PERIOD(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(rst_n), .PacketIn(pkt_b), .ReqUpStr(req_b), .GntUpStr(gnt_b),
    .UpStrFull(full_b), .DrainValid(dv_b), .DrainData(dd_b), .RxCount(rx_b),
    .MisrouteCount(mis_b), .LastSenderID(ls_b), .LastPacketID(lp_b), .CycleCount(cc_b));

  collector_fifo_sink #(.DEPTH(4), .DRAIN_PERIOD(0), .CNT_W(4)) dut_c (
    .clk(clk), .reset(rst_n), .PacketIn(pkt_c), .ReqUpStr(req_c), .GntUpStr(gnt_c),
    .UpStrFull(full_c), .DrainValid(dv_c), .DrainData(dd_c), .RxCount(rx_c),
    .MisrouteCount(mis_c), .LastSenderID(ls_c), .LastPacketID(lp_c), .CycleCount(cc_c));

  function automatic logic [DW-1:0] mk(input int pid, input int dest, input int snd, input int pay);
    return {pid[9:0], dest[5:0], snd[5:0], pay[9:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then score any drained packets against the queues.
  task automatic tick();
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    if (dv_a) begin
      if (q_a.size() == 0) check("a_spurious_drain", 64'(dv_a), 64'd0);
      else begin e = q_a.pop_front(); check("a_drain_data", 64'(dd_a), 64'(e)); end
    end
    if (dv_b) begin
      if (q_b.size() == 0) check("b_spurious_drain", 64'(dv_b), 64'd0);
      else begin e = q_b.pop_front(); check("b_drain_data", 64'(dd_b), 64'(e)); end
    end
    if (dv_c) begin
      if (q_c.size() == 0) check("c_spurious_drain", 64'(dv_c), 64'd0);
      else begin e = q_c.pop_front(); check("c_drain_data", 64'(dd_c), 64'(e)); end
    end
  endtask

  task automatic wait_empty(input int bound);
    int n;
    n = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < bound) begin
      tick();
      n++;
    end
    check("drain_complete", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);
    repeat (3) tick();
  endtask

  initial begin
    int t, g, prev_g;
    int gt[5];
    int exp_gt[5];
    exp_gt = '{1, 3, 5, 7, 10};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 64'(gnt_a), 64'd0);
    check("rst_full", 64'(full_a), 64'd0);
    check("rst_dv", 64'(dv_a), 64'd0);
    check("rst_dd", 64'(dd_a), 64'd0);
    check("rst_rx", 64'(rx_a), 64'd0);
    check("rst_mis", 64'(mis_a), 64'd0);
    check("rst_ls", 64'(ls_a), 64'd0);
    check("rst_lp", 64'(lp_a), 64'd0);
    check("rst_cc", 64'(cc_a), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("cycle_count_3", 64'(cc_a), 64'd3);

    // Single matching packet
    pkt_a = mk(5, 0, 3, 17); q_a.push_back(pkt_a); req_a = 1;
    tick();
    check("t1_gnt_high", 64'(gnt_a), 64'd1);
    req_a = 0;
    tick();
    check("t1_gnt_low", 64'(gnt_a), 64'd0);
    check("t1_rx", 64'(rx_a), 64'd1);
    check("t1_mis", 64'(mis_a), 64'd0);
    check("t1_ls", 64'(ls_a), 64'd3);
    check("t1_lp", 64'(lp_a), 64'd5);
    wait_empty(40);

    // Continuous request into a slow drain: fill, stall, resume after pop
    t = 0; g = 0;
    for (int i = 0; i < 5; i++) gt[i] = 0;
    pkt_a = mk(100, 0, 1, 0); q_a.push_back(pkt_a); req_a = 1;
    while (g < 5 && t < 40) begin
      tick();
      t++;
      if (t == 7 || t == 8) check("t2_full_high", 64'(full_a), 64'd1);
      if (t == 9) begin
        check("t2_full_after_pop", 64'(full_a), 64'd0);
        check("t2_first_pop", 64'(dv_a), 64'd1);
      end
      if (gnt_a) begin
        gt[g] = t;
        g++;
        if (g < 5) begin pkt_a = mk(100 + g, 0, 1 + g, g); q_a.push_back(pkt_a); end
        else req_a = 0;
      end
    end
    req_a = 0;
    check("t2_grant_count", 64'(g), 64'd5);
    for (int i = 0; i < 5; i++) check($sformatf("t2_grant_tick%0d", i), 64'(gt[i]), 64'(exp_gt[i]));
    check("t2_rx", 64'(rx_a), 64'd6);
    wait_empty(100);

    // Misrouted packet is still accepted and drained
    pkt_a = mk(77, 1, 9, 'h2A5); q_a.push_back(pkt_a); req_a = 1;
    tick();
    check("t3_gnt", 64'(gnt_a), 64'd1);
    req_a = 0;
    tick();
    check("t3_mis", 64'(mis_a), 64'd1);
    check("t3_rx", 64'(rx_a), 64'd7);
    check("t3_ls", 64'(ls_a), 64'd9);
    check("t3_lp", 64'(lp_a), 64'd77);
    wait_empty(40);

    // Fast drain: six packets, each popped one cycle after its push
    t = 0; g = 0; prev_g = 0;
    pkt_b = mk(200, 0, 2, 0); q_b.push_back(pkt_b); req_b = 1;
    while (g < 6 && t < 40) begin
      tick();
      t++;
      check("t4_pop_follows_push", 64'(dv_b), 64'(prev_g));
      check("t4_never_full", 64'(full_b), 64'd0);
      prev_g = int'(gnt_b);
      if (gnt_b) begin
        g++;
        if (g < 6) begin pkt_b = mk(200 + g, 0, 2, 'h3F0 + g); q_b.push_back(pkt_b); end
        else req_b = 0;
      end
    end
    req_b = 0;
    tick();
    check("t4_last_pop", 64'(dv_b), 64'(prev_g));
    check("t4_grant_count", 64'(g), 64'd6);
    wait_empty(10);

    // Narrow counters saturate
    t = 0; g = 0;
    pkt_c = mk(300, 2, 4, 0); q_c.push_back(pkt_c); req_c = 1;
    while (g < 17 && t < 80) begin
      tick();
      t++;
      if (gnt_c) begin
        g++;
        if (g < 17) begin pkt_c = mk(300 + g, 2, 4, g); q_c.push_back(pkt_c); end
        else req_c = 0;
      end
    end
    req_c = 0;
    tick();
    check("t5_grant_count", 64'(g), 64'd17);
    check("t5_rx_sat", 64'(rx_c), 64'd15);
    check("t5_mis_sat", 64'(mis_c), 64'd15);
    wait_empty(10);

    // Reset while granting with three buffered packets
    t = 0; g = 0;
    pkt_a = mk(400, 0, 5, 0); req_a = 1;
    while (g < 3 && t < 20) begin
      tick();
      t++;
      if (gnt_a) begin
        g++;
        if (g < 3) pkt_a = mk(400 + g, 0, 5, g);
      end
    end
    check("t6_gnt_before_reset", 64'(gnt_a), 64'd1);
    rst_n = 1'b0;
    req_a = 0;
    #1;
    check("t6_gnt_reset", 64'(gnt_a), 64'd0);
    check("t6_full_reset", 64'(full_a), 64'd0);
    check("t6_cc_reset", 64'(cc_a), 64'd0);
    check("t6_rx_reset", 64'(rx_a), 64'd0);
    check("t6_dv_reset", 64'(dv_a), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("t6_cc_restart", 64'(cc_a), 64'd20);
    check("t6_full_after", 64'(full_a), 64'd0);
    check("t6_rx_after", 64'(rx_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
